// File: rtl/apu_frame_regs.sv
// APU register window $4000-$4017: pulse-channel register bytes, channel restart strobes,
// the $4015 status/enable register and the $4017 frame sequencer with its frame IRQ.
module apu_frame_regs #(
  parameter logic [15:0] Q1 = 16'd7457,
  parameter logic [15:0] Q2 = 16'd14913,
  parameter logic [15:0] Q3 = 16'd22371,
  parameter logic [15:0] Q4 = 16'd29829,
  parameter logic [15:0] Q5 = 16'd37281
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic [4:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       bus_we,
  input  logic       bus_re,
  input  logic [1:0] len_nz,
  output logic [7:0] rdata,
  output logic [7:0] sq1_r0,
  output logic [7:0] sq1_r1,
  output logic [7:0] sq1_r2,
  output logic [7:0] sq1_r3,
  output logic [7:0] sq2_r0,
  output logic [7:0] sq2_r1,
  output logic [7:0] sq2_r2,
  output logic [7:0] sq2_r3,
  output logic       sq1_restart,
  output logic       sq2_restart,
  output logic [1:0] ch_en,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq
);

  logic [7:0]  sq_q [8];
  logic [7:0]  sq_d [8];
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  ch_en_q, ch_en_d;
  logic        mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic        irq_q, irq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        qf_q, qf_d;
  logic        hf_q, hf_d;
  logic        rst1_q, rst1_d;
  logic        rst2_q, rst2_d;

  logic frame_wr, status_rd, tick, at_end, at_step, at_half;

  // A $4017 write restarts the sequence and swallows any coincident CPU tick.
  assign frame_wr  = bus_we && (bus_addr == 5'h17);
  assign status_rd = bus_re && !bus_we && (bus_addr == 5'h15);
  assign tick      = cpu_ce && !frame_wr;
  assign at_end    = mode_q ? (cnt_q == Q5) : (cnt_q == Q4);
  assign at_step   = (cnt_q == Q1) || (cnt_q == Q2) || (cnt_q == Q3) || at_end;
  assign at_half   = (cnt_q == Q2) || at_end;

  always_comb begin
    sq_d    = sq_q;
    ch_en_d = ch_en_q;
    rdata_d = rdata_q;
    rst1_d  = 1'b0;
    rst2_d  = 1'b0;
    if (bus_we) begin
      if (bus_addr[4:3] == 2'b00) begin
        sq_d[bus_addr[2:0]] = bus_wdata;
        rst1_d = (bus_addr[2:0] == 3'd3);
        rst2_d = (bus_addr[2:0] == 3'd7);
      end else if (bus_addr == 5'h15) begin
        ch_en_d = bus_wdata[1:0];
      end
    end else if (bus_re) begin
      rdata_d = (bus_addr == 5'h15) ? {1'b0, irq_q, 4'b0000, len_nz} : 8'h00;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    cnt_d     = cnt_q;
    qf_d      = 1'b0;
    hf_d      = 1'b0;
    if (status_rd) irq_d = 1'b0;
    if (frame_wr) begin
      mode_d    = bus_wdata[7];
      inhibit_d = bus_wdata[6];
      cnt_d     = 16'd0;
      qf_d      = bus_wdata[7];
      hf_d      = bus_wdata[7];
      if (bus_wdata[6]) irq_d = 1'b0;
    end else if (tick) begin
      qf_d  = at_step;
      hf_d  = at_half;
      cnt_d = at_end ? 16'd0 : cnt_q + 16'd1;
      // Setting the IRQ outranks a same-edge status-read clear.
      if (at_end && !mode_q && !inhibit_q) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) sq_q[i] <= 8'h00;
      rdata_q   <= 8'h00;
      ch_en_q   <= 2'b00;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      cnt_q     <= 16'd0;
      qf_q      <= 1'b0;
      hf_q      <= 1'b0;
      rst1_q    <= 1'b0;
      rst2_q    <= 1'b0;
    end else begin
      sq_q      <= sq_d;
      rdata_q   <= rdata_d;
      ch_en_q   <= ch_en_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
      qf_q      <= qf_d;
      hf_q      <= hf_d;
      rst1_q    <= rst1_d;
      rst2_q    <= rst2_d;
    end
  end

  assign rdata         = rdata_q;
  assign sq1_r0        = sq_q[0];
  assign sq1_r1        = sq_q[1];
  assign sq1_r2        = sq_q[2];
  assign sq1_r3        = sq_q[3];
  assign sq2_r0        = sq_q[4];
  assign sq2_r1        = sq_q[5];
  assign sq2_r2        = sq_q[6];
  assign sq2_r3        = sq_q[7];
  assign sq1_restart   = rst1_q;
  assign sq2_restart   = rst2_q;
  assign ch_en         = ch_en_q;
  assign quarter_frame = qf_q;
  assign half_frame    = hf_q;
  assign frame_irq     = irq_q;

endmodule

// File: tb/tb_apu_frame_regs.sv
// Bench for apu_frame_regs: randomized bus traffic against a step-table reference model,
// checked every cycle, plus literal pins on frame step positions and status reads.
module tb_apu_frame_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cpu_ce = 1'b0;
  logic [4:0] bus_addr = 5'h00;
  logic [7:0] bus_wdata = 8'h00;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [1:0] len_nz = 2'b00;
  logic [7:0] rdata;
  logic [7:0] sq1_r0, sq1_r1, sq1_r2, sq1_r3, sq2_r0, sq2_r1, sq2_r2, sq2_r3;
  logic       sq1_restart, sq2_restart, quarter_frame, half_frame, frame_irq;
  logic [1:0] ch_en;

  always #5 clk = ~clk;

  apu_frame_regs dut (
    .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .len_nz(len_nz), .rdata(rdata),
    .sq1_r0(sq1_r0), .sq1_r1(sq1_r1), .sq1_r2(sq1_r2), .sq1_r3(sq1_r3),
    .sq2_r0(sq2_r0), .sq2_r1(sq2_r1), .sq2_r2(sq2_r2), .sq2_r3(sq2_r3),
    .sq1_restart(sq1_restart), .sq2_restart(sq2_restart), .ch_en(ch_en),
    .quarter_frame(quarter_frame), .half_frame(half_frame), .frame_irq(frame_irq)
  );

  logic [7:0] dut_sq [8];
  assign dut_sq[0] = sq1_r0;
  assign dut_sq[1] = sq1_r1;
  assign dut_sq[2] = sq1_r2;
  assign dut_sq[3] = sq1_r3;
  assign dut_sq[4] = sq2_r0;
  assign dut_sq[5] = sq2_r1;
  assign dut_sq[6] = sq2_r2;
  assign dut_sq[7] = sq2_r3;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step positions come from a table, one entry per frame step.
  int         steps0 [4] = '{7457, 14913, 22371, 29829};
  int         steps1 [4] = '{7457, 14913, 22371, 37281};
  logic [7:0] m_sq [8];
  logic [7:0] m_rdata = 8'h00;
  logic [1:0] m_ch_en = 2'b00;
  logic       m_mode = 1'b0, m_inhibit = 1'b0, m_irq = 1'b0;
  logic       m_qf = 1'b0, m_hf = 1'b0, m_r1 = 1'b0, m_r2 = 1'b0;
  int         m_cnt = 0;
  int         ce_n = 0;
  int         hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_sq[i] = 8'h00;
      m_rdata = 8'h00; m_ch_en = 2'b00; m_mode = 1'b0; m_inhibit = 1'b0; m_irq = 1'b0;
      m_qf = 1'b0; m_hf = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0; m_cnt = 0; ce_n = 0;
    end else begin
      m_qf = 1'b0; m_hf = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0;
      if (bus_we) begin
        if (bus_addr <= 5'h07) begin
          m_sq[bus_addr[2:0]] = bus_wdata;
          m_r1 = (bus_addr == 5'h03);
          m_r2 = (bus_addr == 5'h07);
        end else if (bus_addr == 5'h15) begin
          m_ch_en = bus_wdata[1:0];
        end
      end else if (bus_re) begin
        if (bus_addr == 5'h15) begin
          m_rdata = {1'b0, m_irq, 4'b0000, len_nz};
          m_irq = 1'b0;
        end else begin
          m_rdata = 8'h00;
        end
      end
      if (bus_we && bus_addr == 5'h17) begin
        m_mode = bus_wdata[7];
        m_inhibit = bus_wdata[6];
        if (bus_wdata[6]) m_irq = 1'b0;
        m_cnt = 0;
        ce_n = 0;
        m_qf = bus_wdata[7];
        m_hf = bus_wdata[7];
      end else if (cpu_ce) begin
        ce_n++;
        hit = -1;
        for (int k = 0; k < 4; k++)
          if (m_cnt == (m_mode ? steps1[k] : steps0[k])) hit = k;
        if (hit >= 0) begin
          m_qf = 1'b1;
          m_hf = (hit == 1) || (hit == 3);
        end
        if (hit == 3) begin
          m_cnt = 0;
          if (!m_mode && !m_inhibit) m_irq = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  logic [31:0] qf_at [$];
  logic [31:0] hf_at [$];
  logic [31:0] exp_q [$];

  always @(negedge clk) begin
    chk("rdata", 32'(rdata), 32'(m_rdata));
    for (int i = 0; i < 8; i++) chk($sformatf("sq_reg%0d", i), 32'(dut_sq[i]), 32'(m_sq[i]));
    chk("sq1_restart", 32'(sq1_restart), 32'(m_r1));
    chk("sq2_restart", 32'(sq2_restart), 32'(m_r2));
    chk("ch_en", 32'(ch_en), 32'(m_ch_en));
    chk("quarter_frame", 32'(quarter_frame), 32'(m_qf));
    chk("half_frame", 32'(half_frame), 32'(m_hf));
    chk("frame_irq", 32'(frame_irq), 32'(m_irq));
    if (quarter_frame === 1'b1) qf_at.push_back(32'(ce_n));
    if (half_frame === 1'b1) hf_at.push_back(32'(ce_n));
  end

  task automatic drive(input logic we, input logic re, input logic [4:0] a, input logic [7:0] d,
                       input logic ce, input logic [1:0] ln);
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d; cpu_ce = ce; len_nz = ln;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input logic ce, input bit allow_frame);
    logic [4:0] a;
    a = 5'($urandom_range(0, 31));
    if (!allow_frame && a == 5'h17) a = 5'h15;
    drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, a, 8'($urandom), ce,
          2'($urandom_range(0, 3)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_sq%0d", tag, i), 32'(dut_sq[i]), 32'h0);
    chk({tag, "_restarts"}, 32'({sq1_restart, sq2_restart}), 32'h0);
    chk({tag, "_ch_en"}, 32'(ch_en), 32'h0);
    chk({tag, "_frame_strobes"}, 32'({quarter_frame, half_frame}), 32'h0);
    chk({tag, "_frame_irq"}, 32'(frame_irq), 32'h0);
  endtask

  task automatic chk_steps(input string name, input bit use_half);
    int n;
    n = use_half ? hf_at.size() : qf_at.size();
    chk({name, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk(name, use_half ? hf_at[i] : qf_at[i], exp_q[i]);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_zero("reset");

    drive(1'b1, 1'b0, 5'h00, 8'hBF, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 5'h03, 8'h08, 1'b0, 2'b00);
    chk("wr_sq1_r0", 32'(sq1_r0), 32'hBF);
    chk("wr_sq1_r3", 32'(sq1_r3), 32'h08);
    chk("wr_sq1_restart_on", 32'(sq1_restart), 32'h1);
    chk("wr_sq2_untouched", 32'({sq2_r0, sq2_r1, sq2_r2, sq2_r3, 7'b0, sq2_restart}), 32'h0);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 2'b00);
    chk("wr_sq1_restart_off", 32'(sq1_restart), 32'h0);
    drive(1'b1, 1'b0, 5'h07, 8'h55, 1'b0, 2'b00);
    chk("wr_sq2_r3", 32'(sq2_r3), 32'h55);
    chk("wr_sq2_restart_on", 32'(sq2_restart), 32'h1);
    drive(1'b1, 1'b0, 5'h15, 8'hFE, 1'b0, 2'b00);
    chk("wr_ch_en", 32'(ch_en), 32'h2);
    chk("wr_sq2_restart_off", 32'(sq2_restart), 32'h0);
    drive(1'b0, 1'b1, 5'h15, 8'h00, 1'b0, 2'b01);
    chk("rd_status_idle", 32'(rdata), 32'h01);
    drive(1'b1, 1'b1, 5'h02, 8'hA5, 1'b0, 2'b10);
    chk("rd_we_re_hold", 32'(rdata), 32'h01);
    chk("rd_we_re_write", 32'(sq1_r2), 32'hA5);
    drive(1'b0, 1'b1, 5'h04, 8'h00, 1'b0, 2'b11);
    chk("rd_other", 32'(rdata), 32'h00);

    repeat (200) rand_op(1'b0, 1'b1);
    drive(1'b1, 1'b0, 5'h17, 8'h00, 1'b0, 2'b00);

    // Count part-way into a frame with gapped ticks, then reset asynchronously.
    qf_at.delete(); hf_at.delete();
    for (int i = 0; i < 20000 && ce_n < 9000; i++) rand_op($urandom_range(0, 7) != 0, 1'b0);
    exp_q = '{32'd7458};
    chk_steps("gapped_qf", 1'b0);
    exp_q = '{};
    chk_steps("gapped_hf", 1'b1);
    drive(1'b1, 1'b0, 5'h00, 8'h5A, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 5'h15, 8'h03, 1'b0, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 2'b00);
    rst_n = 1'b1;

    // Mode 0 frame with a tick every clock; status read lands on the IRQ-set edge.
    qf_at.delete(); hf_at.delete();
    for (int i = 1; i <= 29840; i++) begin
      if (i == 29830 || i == 29831) drive(1'b0, 1'b1, 5'h15, 8'h00, 1'b1, 2'b10);
      else rand_op(1'b1, 1'b0);
      if (i == 29830) begin
        chk("irq_set_beats_clear", 32'(frame_irq), 32'h1);
        chk("rd_status_at_set", 32'(rdata), 32'h02);
      end
      if (i == 29831) begin
        chk("rd_status_irq", 32'(rdata), 32'h42);
        chk("irq_cleared_by_read", 32'(frame_irq), 32'h0);
      end
    end
    exp_q = '{32'd7458, 32'd14914, 32'd22372, 32'd29830};
    chk_steps("mode0_qf", 1'b0);
    exp_q = '{32'd14914, 32'd29830};
    chk_steps("mode0_hf", 1'b1);

    // Switch to 5-step mode mid-count.
    repeat (500) rand_op(1'b1, 1'b0);
    qf_at.delete(); hf_at.delete();
    drive(1'b1, 1'b0, 5'h17, 8'h80, 1'b1, 2'b00);
    chk("mode1_wr_qf", 32'(quarter_frame), 32'h1);
    chk("mode1_wr_hf", 32'(half_frame), 32'h1);
    repeat (37290) rand_op(1'b1, 1'b0);
    exp_q = '{32'd0, 32'd7458, 32'd14914, 32'd22372, 32'd37282};
    chk_steps("mode1_qf", 1'b0);
    exp_q = '{32'd0, 32'd14914, 32'd37282};
    chk_steps("mode1_hf", 1'b1);
    chk("mode1_no_irq", 32'(frame_irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
